mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit that owns the architectural HI/LO registers for the MIPS core.
- Executes MULT, MULTU, DIV and DIVU as radix-2 sequential operations (shift-add multiply, restoring divide), plus single-cycle MTHI and MTLO.
- Sits beside the ALU. The core stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (localparam, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  launch request; sampled only in IDLE.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved.
- rs_val  input  WIDTH  multiplicand/dividend, or MTHI/MTLO source.
- rt_val  input  WIDTH  multiplier/divisor.
- cancel  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  high whenever state≠IDLE.
- done  output  1  one-cycle pulse when HI/LO commit from a MULT/DIV.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, working registers=0. Asserting reset mid-operation abandons the operation immediately.
- States: IDLE → CALC → FIX → IDLE.
- IDLE, start=1, op 0–3:
  - Latch operand magnitudes and the result-sign flags. For signed ops, a negative operand is replaced by its two's-complement magnitude.
  - counter=WIDTH; go to CALC.
- IDLE, start=1, op 4/5: write hi (4) or lo (5) from rs_val on the same edge. No busy, no done.
- IDLE, start=1, op 6/7: ignored.
- CALC: one radix-2 step per edge; counter decrements; at counter==1 the next state is FIX. CALC lasts exactly WIDTH edges.
- Multiply step: {acc,mplr} shifts right. If mplr[0]=1, add the multiplicand to acc first, with a WIDTH+1-bit sum whose carry is kept.
- Divide step: shift {rem,quo} left, then trial-subtract the divisor using WIDTH+1 bits. A non-negative trial result commits and sets quo[0]=1.
- FIX: apply sign correction and commit HI/LO; done=1 in the following cycle; return to IDLE.
  - Mult result is the 2·WIDTH product {hi,lo}, negated if the sign flag is set.
  - Div results are lo=quotient and hi=remainder. The quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
- Latency: from the start edge, hi/lo update on edge WIDTH+2 (34 at default). busy is high for WIDTH+1 cycles; done pulses 1 cycle.
- start while busy: ignored, with no queueing. The core must wait for !busy.
- cancel=1 in CALC or FIX: return to IDLE next edge; hi/lo unchanged; no done. cancel in IDLE has no effect, and cancel has priority over start.
- Divide by zero, commit without a fault:
  - DIVU: lo=all-ones, hi=dividend.
  - DIV: lo=+1 if dividend<0 else all-ones; hi=dividend.
- Signed overflow, DIV MIN/−1: lo=MIN (10…0), hi=0.
- hi/lo are stable whenever busy=0.

Optional Feature:
- Macro MDU_EARLY_TERM_EN.
- Defined: in CALC for multiply, if all remaining unconsumed multiplier bits are zero, jump to FIX next edge. acc and mplr are aligned by the outstanding shift count, so the result is identical. Divide latency is unchanged. Minimum multiply latency is 3 edges (e.g. rt_val=0).
- Undefined: fixed WIDTH+2 latency for all arithmetic ops.

Decomposition:
- Package mdu_pkg:
  - op encoding typedef (MDU_MULT…MDU_MTLO);
  - state enum (S_IDLE, S_CALC, S_FIX);
  - function for the WIDTH-generic MIN constant.
- Sub-module mdu_abs_neg: combinational conditional two's-complement negate, parametrised width. Instantiated for operand magnitude (WIDTH) and for result fix-up (2·WIDTH for the product, WIDTH for quotient and remainder).
- Datapath and FSM stay in mdu_iter.

Test Plan:
- MULT rs=0xFFFFFFFD (−3), rt=5 → after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFFF1, one-cycle done, busy high 33 cycles.
- MULTU rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. With MDU_EARLY_TERM_EN, MULTU rs=9, rt=2 → hi=0, lo=18 in fewer than 34 edges.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 → lo=0xFFFFFFFF, hi=7. DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI rs=0x12345678 → hi updates next edge, busy/done stay 0. Then a second start with op=MULT while busy is ignored, and the first result commits unchanged.
- cancel at CALC cycle 10 → busy drops next edge, no done, hi/lo keep the prior values.
- rst asserted asynchronously mid-CALC → busy=0, hi=lo=0 immediately. A new MULTU 3×4 after release → lo=12.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the iterative multiply/divide unit.
//   mdu_op_e    - operation encoding on the op port (6/7 reserved)
//   mdu_state_e - sequencer states
//   mdu_min     - most-negative two's-complement value for a given width
package mdu_pkg;

  // Widest operand the MIN helper can describe.
  localparam int MDU_MAX_W = 128;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } mdu_state_e;

  // Only bit width-1 is set; callers keep the low width bits.
  function automatic logic [MDU_MAX_W-1:0] mdu_min(input int width);
    logic [MDU_MAX_W-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// mdu_abs_neg: conditional two's-complement negate.
//   W   - data width
//   a   - input value
//   neg - 1 to negate, 0 to pass through
//   y   - result
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? -a : a;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, both on operand
// magnitudes with a sign fix-up in S_FIX. MTHI/MTLO write in a single edge.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - launch request, sampled only in S_IDLE
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   rs_val - multiplicand / dividend / MTHI-MTLO source
//   rt_val - multiplier / divisor
//   cancel - abort the in-flight operation (also suppresses a start in S_IDLE)
//   busy   - high whenever not idle
//   done   - one-cycle pulse after HI/LO commit from a MULT/DIV
//   hi, lo - architectural HI/LO registers
//
// Build option: MDU_EARLY_TERM_EN ends a multiply as soon as the remaining
// multiplier bits are all zero.
//
// state  | meaning
// S_IDLE | waiting for start; hi/lo stable
// S_CALC | one radix-2 step per edge, cnt counts remaining steps
// S_FIX  | sign correction and HI/LO commit
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [MDU_MAX_W-1:0] MIN_FULL = mdu_min(WIDTH);
  localparam logic [WIDTH-1:0]     MIN_VAL  = MIN_FULL[WIDTH-1:0];

  mdu_state_e       state, state_nxt;
  mdu_op_e          op_e;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;   // product high half / partial remainder
  logic [WIDTH-1:0] wrk;   // multiplier shifting out, product low half / quotient
  logic [WIDTH-1:0] opnd;  // multiplicand or divisor magnitude
  logic             is_div, neg_q, neg_r, ovf;

  logic             is_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] acc_step, wrk_step;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0] quo_res, rem_res;
  logic             early;

  assign op_e      = mdu_op_e'(op);
  assign is_signed = (op_e == MDU_MULT) || (op_e == MDU_DIV);
  assign busy      = (state != S_IDLE);

  mdu_abs_neg #(.W(WIDTH)) u_abs_a (.a(rs_val), .neg(is_signed && rs_val[WIDTH-1]), .y(a_mag));
  mdu_abs_neg #(.W(WIDTH)) u_abs_b (.a(rt_val), .neg(is_signed && rt_val[WIDTH-1]), .y(b_mag));

  mdu_abs_neg #(.W(2*WIDTH)) u_fix_prod (.a({acc, wrk}), .neg(neg_q), .y(prod_res));
  mdu_abs_neg #(.W(WIDTH))   u_fix_quo  (.a(wrk),        .neg(neg_q), .y(quo_res));
  mdu_abs_neg #(.W(WIDTH))   u_fix_rem  (.a(acc),        .neg(neg_r), .y(rem_res));

  // One radix-2 step. The multiply sum keeps its carry, which becomes the new
  // top bit of acc after the right shift. The divide trial is WIDTH+1 bits so
  // the borrow doubles as the "negative" flag.
  always_comb begin
    mul_sum   = {1'b0, acc} + (wrk[0] ? {1'b0, opnd} : '0);
    div_trial = {acc, wrk[WIDTH-1]} - {1'b0, opnd};
    acc_step  = mul_sum[WIDTH:1];
    wrk_step  = {mul_sum[0], wrk[WIDTH-1:1]};
    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        acc_step = div_trial[WIDTH-1:0];
        wrk_step = {wrk[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc[WIDTH-2:0], wrk[WIDTH-1]};
        wrk_step = {wrk[WIDTH-2:0], 1'b0};
      end
    end
  end

`ifdef MDU_EARLY_TERM_EN
  // The low cnt bits of wrk are the multiplier bits not yet consumed. When they
  // are all zero the remaining steps are pure shifts, done here in one go.
  logic [WIDTH-1:0]   rem_mask;
  logic [2*WIDTH-1:0] aligned;
  assign rem_mask = ~({WIDTH{1'b1}} << cnt);
  assign early    = !is_div && ((wrk & rem_mask) == '0);
  assign aligned  = {acc, wrk} >> cnt;
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !cancel && !op[2]) state_nxt = S_CALC;
      S_CALC: begin
        if (cancel)                                state_nxt = S_IDLE;
        else if (early || cnt == CNT_W'(1))        state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      acc   <= '0;
      wrk   <= '0;
      opnd  <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        S_IDLE: if (start && !cancel) begin
          case (op_e)
            MDU_MTHI: hi <= rs_val;
            MDU_MTLO: lo <= rs_val;
            MDU_MULT, MDU_MULTU: begin
              acc    <= '0;
              wrk    <= b_mag;
              opnd   <= a_mag;
              is_div <= 1'b0;
              neg_q  <= is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_r  <= 1'b0;
              ovf    <= 1'b0;
              cnt    <= CNT_W'(WIDTH);
            end
            MDU_DIV, MDU_DIVU: begin
              acc    <= '0;
              wrk    <= a_mag;
              opnd   <= b_mag;
              is_div <= 1'b1;
              neg_q  <= is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_r  <= is_signed && rs_val[WIDTH-1];
              ovf    <= (op_e == MDU_DIV) && (rs_val == MIN_VAL) && (rt_val == '1);
              cnt    <= CNT_W'(WIDTH);
            end
            default: ;
          endcase
        end
        S_CALC: if (!cancel) begin
`ifdef MDU_EARLY_TERM_EN
          if (early) begin
            {acc, wrk} <= aligned;
            cnt        <= '0;
          end else
`endif
          begin
            acc <= acc_step;
            wrk <= wrk_step;
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_FIX: if (!cancel) begin
          done <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= prod_res;
          end else if (ovf) begin
            lo <= MIN_VAL;
            hi <= '0;
          end else begin
            lo <= quo_res;
            hi <= rem_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk, rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_fail = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .cancel(cancel), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge. inj: 0 none, 1 extra start, 2 cancel,
  // applied after the inj_at-th edge and removed one edge later.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input int inj_at,
                        output int edges, output int busy_cyc, output int done_cyc);
    edges = 0; busy_cyc = 0; done_cyc = 0;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc++;
        if (edges == 0) edges = i;
      end
      if (inj != 0 && i == inj_at + 1) begin
        start = 1'b0; cancel = 1'b0; op = o; rs_val = a; rt_val = b;
      end
      if (inj == 1 && i == inj_at) begin
        start = 1'b1; op = OP_MULT; rs_val = 32'd100; rt_val = 32'd100;
      end
      if (inj == 2 && i == inj_at) cancel = 1'b1;
      if (edges != 0 && i >= edges + 2) break;
    end
  endtask

  initial begin
    int e, bc, dc;
    logic is_mul;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'd1};
    vecs[6]  = '{OP_DIV,   32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[7]  = '{OP_MULT,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[9]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
    vecs[12] = '{OP_MULTU, 32'h12345678, 32'h10,       32'd1,        32'h23456780};
    vecs[13] = '{OP_MULT,  32'd0,        32'hFFFFFFFF, 32'd0,        32'd0};
    vecs[14] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 15; k++) begin
      run_op(vecs[k].op, vecs[k].a, vecs[k].b, 0, 0, e, bc, dc);
      is_mul = (vecs[k].op == OP_MULT) || (vecs[k].op == OP_MULTU);
      check($sformatf("vec%0d_hi", k), hi, vecs[k].ehi);
      check($sformatf("vec%0d_lo", k), lo, vecs[k].elo);
      check($sformatf("vec%0d_done_cycles", k), dc, 1);
`ifdef MDU_EARLY_TERM_EN
      if (is_mul) check($sformatf("vec%0d_edges_le_34", k), (e >= 3 && e <= 34), 1);
      else begin
        check($sformatf("vec%0d_edges", k), e, 34);
        check($sformatf("vec%0d_busy_cycles", k), bc, 33);
      end
`else
      check($sformatf("vec%0d_edges", k), e, 34);
      check($sformatf("vec%0d_busy_cycles", k), bc, 33);
      check($sformatf("vec%0d_is_mul_seen", k), is_mul, (k == 0 || k == 1 || k == 7 || k == 8 || k == 12 || k == 13));
`endif
    end

    // MTHI / MTLO: single edge, no busy, no done.
    op = OP_MTHI; rs_val = 32'h12345678; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    op = OP_MTLO; rs_val = 32'hCAFEF00D; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("mtlo_lo", lo, 32'hCAFEF00D);
    check("mtlo_hi_kept", hi, 32'h12345678);
    check("mtlo_busy", busy, 0);

    // Reserved op is ignored.
    op = 3'd6; rs_val = 32'hDEADBEEF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("rsvd_busy", busy, 0);
    check("rsvd_hi", hi, 32'h12345678);
    check("rsvd_lo", lo, 32'hCAFEF00D);

    // Second start while busy is dropped.
    run_op(OP_MULT, 32'd3, 32'd5, 1, 3, e, bc, dc);
    check("busy_start_hi", hi, 0);
    check("busy_start_lo", lo, 15);
    check("busy_start_done", dc, 1);
`ifndef MDU_EARLY_TERM_EN
    check("busy_start_edges", e, 34);
`endif

    // Cancel after CALC cycle 10: busy drops, no done, hi/lo keep 0 / 15.
    run_op(OP_DIVU, 32'd1000, 32'd3, 2, 10, e, bc, dc);
    check("cancel_busy_cycles", bc, 10);
    check("cancel_done", dc, 0);
    check("cancel_busy_now", busy, 0);
    check("cancel_hi", hi, 0);
    check("cancel_lo", lo, 15);

    // Asynchronous reset in the middle of CALC.
    op = OP_MTHI; rs_val = 32'h55AA55AA; start = 1'b1;
    @(posedge clk); #1;
    op = OP_DIV; rs_val = 32'd77; rt_val = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_done", done, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(OP_MULTU, 32'd3, 32'd4, 0, 0, e, bc, dc);
    check("after_rst_lo", lo, 12);
    check("after_rst_hi", hi, 0);
    check("after_rst_done", dc, 1);

`ifdef MDU_EARLY_TERM_EN
    run_op(OP_MULTU, 32'd9, 32'd2, 0, 0, e, bc, dc);
    check("early_lo", lo, 18);
    check("early_hi", hi, 0);
    check("early_edges", e, 5);
    run_op(OP_MULTU, 32'd9, 32'd0, 0, 0, e, bc, dc);
    check("early_zero_edges", e, 3);
    check("early_zero_lo", lo, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
